// File: rtl/direction_queue.sv
// direction_queue: turn-command FIFO between the NEC IR decoder and the snake
// movement logic. Redundant turns (same heading) and reversals are filtered at
// push time against the newest queued entry, or against heading when the queue
// is empty. One entry is released per game tick while RUNNING.
// Optional build macro DIRQ_DROP_CNT_EN adds drop_count / drop_pulse.
module direction_queue #(
    parameter int         DEPTH    = 4,
    parameter logic [1:0] INIT_DIR = 2'd3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               dir_in,
    input  logic                     dir_valid,
    input  logic                     game_tick,
    input  logic                     clear,
    output logic [1:0]               heading,
    output logic                     running,
    output logic                     turn_taken,
    output logic [$clog2(DEPTH):0]   count
`ifdef DIRQ_DROP_CNT_EN
    ,
    output logic [7:0]               drop_count,
    output logic                     drop_pulse
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {STOPPED = 1'b0, RUNNING = 1'b1} state_t;

    state_t         state, next_state;
    logic [1:0]     mem [DEPTH];
    logic [AW:0]    wr_ptr, rd_ptr;
    logic [AW-1:0]  last_idx;
    logic [1:0]     ref_dir;
    logic           full, accept, push, pop;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign count    = wr_ptr - rd_ptr;
    assign full     = (count == (AW+1)'(DEPTH));
    assign last_idx = wr_ptr[AW-1:0] - AW'(1);
    assign ref_dir  = (count != '0) ? mem[last_idx] : heading;

    // A turn is useful only if it is neither a repeat nor a reversal of the
    // direction the snake will be travelling when it is applied.
    assign accept = (dir_in != ref_dir) && (dir_in != (ref_dir ^ 2'b01)) && !full;
    assign push   = dir_valid && !clear && accept;
    assign pop    = game_tick && !clear && (state == RUNNING) && (count != '0);

    assign running = (state == RUNNING);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= STOPPED;
        else       state <= next_state;
    end

    // Next state: first accepted push starts the game, clear stops it.
    always_comb begin
        next_state = state;
        if (clear)
            next_state = STOPPED;
        else if (state == STOPPED && push)
            next_state = RUNNING;
    end

    // Read/write pointers; reset and clear both flush the queue.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= dir_in;
    end

    // Heading update and turn pulse; clear deliberately keeps heading.
    always_ff @(posedge clk) begin
        if (reset) begin
            heading    <= INIT_DIR;
            turn_taken <= 1'b0;
        end else begin
            turn_taken <= pop;
            if (pop) heading <= mem[rd_ptr[AW-1:0]];
        end
    end

`ifdef DIRQ_DROP_CNT_EN
    logic drop;
    assign drop = dir_valid && !clear && !accept;

    // Saturating reject counter and one-cycle reject flag.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            drop_count <= 8'd0;
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= drop;
            if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_direction_queue.sv
// Self-checking bench for direction_queue (DEPTH=4, INIT_DIR=3).
// Table rows are one clock edge each; turns expected by the table are pushed to
// a scoreboard and popped when the DUT raises turn_taken.
module tb_direction_queue;

    logic       clk = 1'b0;
    logic       reset, dir_valid, game_tick, clear;
    logic [1:0] dir_in;
    logic [1:0] heading;
    logic       running, turn_taken;
    logic [2:0] count;
`ifdef DIRQ_DROP_CNT_EN
    logic [7:0] drop_count;
    logic       drop_pulse;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    direction_queue #(.DEPTH(4), .INIT_DIR(2'd3)) dut (
        .clk        (clk),
        .reset      (reset),
        .dir_in     (dir_in),
        .dir_valid  (dir_valid),
        .game_tick  (game_tick),
        .clear      (clear),
        .heading    (heading),
        .running    (running),
        .turn_taken (turn_taken),
        .count      (count)
`ifdef DIRQ_DROP_CNT_EN
        ,
        .drop_count (drop_count),
        .drop_pulse (drop_pulse)
`endif
    );

    typedef struct {
        logic       rst, dv;
        logic [1:0] d;
        logic       tk, clr;
        logic [1:0] h;
        logic       run;
        logic [2:0] cnt;
        logic       tt;
        logic [7:0] dc;
    } vec_t;

    vec_t       tbl[$];
    logic [1:0] sb_q[$];

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s step%0d: got %0d want %0d", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic dv, input logic [1:0] d, input logic tk,
                       input logic clr, input logic [1:0] h, input logic run,
                       input logic [2:0] cnt, input logic tt, input logic [7:0] dc);
        vec_t v;
        v.rst = rst; v.dv = dv; v.d = d; v.tk = tk; v.clr = clr;
        v.h = h; v.run = run; v.cnt = cnt; v.tt = tt; v.dc = dc;
        tbl.push_back(v);
    endtask

    // Drive one row on the falling edge, let the rising edge act, then check.
    task automatic step(input vec_t v, input int idx);
        @(negedge clk);
        reset = v.rst; dir_valid = v.dv; dir_in = v.d; game_tick = v.tk; clear = v.clr;
        if (v.tt) sb_q.push_back(v.h);
        @(posedge clk);
        #1;
        reset = 1'b0; dir_valid = 1'b0; game_tick = 1'b0; clear = 1'b0;
        chk("heading", idx, int'(heading), int'(v.h));
        chk("running", idx, int'(running), int'(v.run));
        chk("count", idx, int'(count), int'(v.cnt));
        chk("turn_taken", idx, int'(turn_taken), int'(v.tt));
`ifdef DIRQ_DROP_CNT_EN
        chk("drop_count", idx, int'(drop_count), int'(v.dc));
`endif
    endtask

    // Scoreboard: each turn_taken pulse must match the oldest expected turn.
    always @(negedge clk) begin
        if (turn_taken) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_turn: got heading %0d want no turn", heading);
            end else begin
                logic [1:0] e;
                e = sb_q.pop_front();
                if (heading != e) begin
                    failures++;
                    $display("FAIL sb_turn: got heading %0d want %0d", heading, e);
                end
            end
        end
    end

    initial begin
        vec_t v;
        reset = 1'b1; dir_valid = 1'b0; dir_in = 2'd0; game_tick = 1'b0; clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_heading", 0, int'(heading), 3);
        chk("rst_running", 0, int'(running), 0);
        chk("rst_count", 0, int'(count), 0);
        chk("rst_turn", 0, int'(turn_taken), 0);
        reset = 1'b0;

        //   rst dv d    tk clr  h    run cnt  tt dc
        // push up, one tick
        add(0, 1, 2'd0, 0, 0, 2'd3, 1, 3'd1, 0, 8'd0);
        add(0, 0, 2'd0, 1, 0, 2'd0, 1, 3'd0, 1, 8'd0);
        add(0, 0, 2'd0, 0, 0, 2'd0, 1, 3'd0, 0, 8'd0);
        // reversal and duplicate against heading=3
        add(1, 0, 2'd0, 0, 0, 2'd3, 0, 3'd0, 0, 8'd0);
        add(0, 1, 2'd2, 0, 0, 2'd3, 0, 3'd0, 0, 8'd1);
        add(0, 1, 2'd3, 0, 0, 2'd3, 0, 3'd0, 0, 8'd2);
        // two presses inside one tick period
        add(0, 1, 2'd0, 0, 0, 2'd3, 1, 3'd1, 0, 8'd2);
        add(0, 1, 2'd2, 0, 0, 2'd3, 1, 3'd2, 0, 8'd2);
        add(0, 0, 2'd0, 1, 0, 2'd0, 1, 3'd1, 1, 8'd2);
        add(0, 0, 2'd0, 1, 0, 2'd2, 1, 3'd0, 1, 8'd2);
        // fill to DEPTH, drop on full, drain, then wrap pointers
        add(1, 0, 2'd0, 0, 0, 2'd3, 0, 3'd0, 0, 8'd0);
        add(0, 1, 2'd0, 0, 0, 2'd3, 1, 3'd1, 0, 8'd0);
        add(0, 1, 2'd2, 0, 0, 2'd3, 1, 3'd2, 0, 8'd0);
        add(0, 1, 2'd1, 0, 0, 2'd3, 1, 3'd3, 0, 8'd0);
        add(0, 1, 2'd3, 0, 0, 2'd3, 1, 3'd4, 0, 8'd0);
        add(0, 1, 2'd0, 0, 0, 2'd3, 1, 3'd4, 0, 8'd1);
        add(0, 0, 2'd0, 1, 0, 2'd0, 1, 3'd3, 1, 8'd1);
        add(0, 0, 2'd0, 1, 0, 2'd2, 1, 3'd2, 1, 8'd1);
        add(0, 0, 2'd0, 1, 0, 2'd1, 1, 3'd1, 1, 8'd1);
        add(0, 0, 2'd0, 1, 0, 2'd3, 1, 3'd0, 1, 8'd1);
        add(0, 0, 2'd0, 1, 0, 2'd3, 1, 3'd0, 0, 8'd1);
        add(0, 1, 2'd0, 0, 0, 2'd3, 1, 3'd1, 0, 8'd1);
        add(0, 1, 2'd3, 0, 0, 2'd3, 1, 3'd2, 0, 8'd1);
        add(0, 0, 2'd0, 1, 0, 2'd0, 1, 3'd1, 1, 8'd1);
        add(0, 0, 2'd0, 1, 0, 2'd3, 1, 3'd0, 1, 8'd1);
        // same-cycle push and pop, reference uses pre-pop tail
        add(1, 0, 2'd0, 0, 0, 2'd3, 0, 3'd0, 0, 8'd0);
        add(0, 1, 2'd0, 0, 0, 2'd3, 1, 3'd1, 0, 8'd0);
        add(0, 1, 2'd2, 1, 0, 2'd0, 1, 3'd1, 1, 8'd0);
        add(0, 0, 2'd0, 1, 0, 2'd2, 1, 3'd0, 1, 8'd0);
        // clear beats dir_valid; heading survives; restart afterwards
        add(1, 0, 2'd0, 0, 0, 2'd3, 0, 3'd0, 0, 8'd0);
        add(0, 1, 2'd0, 0, 0, 2'd3, 1, 3'd1, 0, 8'd0);
        add(0, 1, 2'd2, 0, 0, 2'd3, 1, 3'd2, 0, 8'd0);
        add(0, 0, 2'd0, 1, 0, 2'd0, 1, 3'd1, 1, 8'd0);
        add(0, 1, 2'd1, 0, 0, 2'd0, 1, 3'd2, 0, 8'd0);
        add(0, 1, 2'd3, 0, 1, 2'd0, 0, 3'd0, 0, 8'd0);
        add(0, 0, 2'd0, 1, 0, 2'd0, 0, 3'd0, 0, 8'd0);
        add(0, 1, 2'd2, 0, 0, 2'd0, 1, 3'd1, 0, 8'd0);

        foreach (tbl[i]) step(tbl[i], i + 1);

        // Hand sequence: clear wins over a simultaneous tick with a queued turn.
        v = '{rst:1, dv:0, d:2'd0, tk:0, clr:0, h:2'd3, run:0, cnt:3'd0, tt:0, dc:8'd0};
        step(v, 100);
        v = '{rst:0, dv:1, d:2'd1, tk:0, clr:0, h:2'd3, run:1, cnt:3'd1, tt:0, dc:8'd0};
        step(v, 101);
        v = '{rst:0, dv:0, d:2'd0, tk:1, clr:1, h:2'd3, run:0, cnt:3'd0, tt:0, dc:8'd0};
        step(v, 102);
        // Hand sequence: tick while STOPPED with empty queue does nothing.
        v = '{rst:0, dv:0, d:2'd0, tk:1, clr:0, h:2'd3, run:0, cnt:3'd0, tt:0, dc:8'd0};
        step(v, 103);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_leftover", 200, sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
